// File: rtl/dt_sti_loader_if.sv
// dt_sti_loader_if: start/status, stimulus ROM and result RAM signals of the loader
interface dt_sti_loader_if;
  logic        start;
  logic        busy;
  logic        done;
  logic        sti_rd;
  logic [9:0]  sti_addr;
  logic [15:0] sti_di;
  logic        res_wr;
  logic [13:0] res_addr;
  logic [7:0]  res_do;
  logic [14:0] obj_cnt;
  logic [6:0]  row_first;
  logic [6:0]  row_last;
  logic        row_valid;
  modport master (
    output start, sti_di,
    input  busy, done, sti_rd, sti_addr, res_wr, res_addr, res_do,
           obj_cnt, row_first, row_last, row_valid
  );
  modport slave (
    input  start, sti_di,
    output busy, done, sti_rd, sti_addr, res_wr, res_addr, res_do,
           obj_cnt, row_first, row_last, row_valid
  );
endinterface

// File: rtl/dt_sti_loader.sv
// dt_sti_loader: unpacks the 1bpp 128x128 ROM image into the 8bpp RAM and gathers object row statistics
module dt_sti_loader #(
  parameter logic [7:0] OBJ_VAL     = 8'd1,
  parameter bit         BORDER_ZERO = 1'b1
) (
  input logic           clk,
  input logic           reset,
  dt_sti_loader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;
  state_t      state_q, state_d;
  logic [13:0] k_q, k_d;
  logic [15:0] sh_q, sh_d;
  logic [9:0]  addr_q, addr_d;
  logic [14:0] cnt_q, cnt_d;
  logic [6:0]  rf_q, rf_d, rl_q, rl_d;
  logic        rv_q, rv_d, done_q, done_d;
  logic        fetch, wr, last, pref, accept, border, pix, obj, rd;
  logic [6:0]  row, col;
  logic [9:0]  rd_addr;
  assign row     = k_q[13:7];
  assign col     = k_q[6:0];
  assign fetch   = state_q == FETCH;
  assign wr      = state_q == WRITE;
  assign last    = &k_q;
  assign accept  = bus.start && (state_q == IDLE || state_q == DONE);
  // last nibble of each word prefetches the next one, except after the final word
  assign pref    = wr && &k_q[3:0] && !last;
  assign border  = BORDER_ZERO && (~|row || &row || ~|col || &col);
  assign pix     = sh_q[15] && !border;
  assign obj     = wr && pix;
  assign rd      = fetch || pref;
  assign rd_addr = fetch ? 10'd0 : k_q[13:4] + 10'd1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  always_comb
    state_d = accept ? FETCH :
              fetch ? WRITE :
              (wr && last) ? DONE :
              state_q == DONE ? IDLE : state_q;
  always_comb begin
    k_d    = fetch ? 14'd0 : (wr && !last) ? k_q + 14'd1 : k_q;
    sh_d   = rd ? bus.sti_di : (wr && !last) ? sh_q << 1 : sh_q;
    addr_d = rd ? rd_addr : addr_q;
    cnt_d  = accept ? 15'd0 : obj ? cnt_q + 15'd1 : cnt_q;
    rf_d   = accept ? 7'd0 : (obj && !rv_q) ? row : rf_q;
    rl_d   = accept ? 7'd0 : obj ? row : rl_q;
    rv_d   = !accept && (obj || rv_q);
    done_d = !accept && ((wr && last) || done_q);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      k_q    <= '0;
      sh_q   <= '0;
      addr_q <= '0;
      cnt_q  <= '0;
      rf_q   <= '0;
      rl_q   <= '0;
      rv_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      k_q    <= k_d;
      sh_q   <= sh_d;
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      rf_q   <= rf_d;
      rl_q   <= rl_d;
      rv_q   <= rv_d;
      done_q <= done_d;
    end
  always_comb begin
    bus.busy      = fetch || wr;
    bus.done      = done_q;
    bus.sti_rd    = rd;
    bus.sti_addr  = rd ? rd_addr : addr_q;
    bus.res_wr    = wr;
    bus.res_addr  = k_q;
    bus.res_do    = pix ? OBJ_VAL : 8'd0;
    bus.obj_cnt   = cnt_q;
    bus.row_first = rf_q;
    bus.row_last  = rl_q;
    bus.row_valid = rv_q;
  end
endmodule

// File: doc/dt_sti_loader.md
# dt_sti_loader

Loader stage that runs directly upstream of the distance-transform forward pass. It reads the packed 1-bit-per-pixel 128x128 binary image from the stimulus ROM (1024 words x 16 bits) and unpacks it into the 8-bit-per-pixel result RAM: object pixels become OBJ_VAL and background pixels become 0. While it loads, it gathers object statistics (pixel count, first and last occupied row) so that the downstream passes can skip empty rows.

## Interface
- OBJ_VAL, 8'd1: value written for an object pixel (ROM bit = 1).
- BORDER_ZERO, 1: when 1, every pixel on row 0, row 127, col 0 or col 127 is written as 0 regardless of the ROM bit.
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  start request, sampled on posedge when busy=0.
- busy  out  1  high from the first FETCH cycle through the last write cycle.
- done  out  1  level; set after the last write; cleared by reset or by an accepted start.
- sti_rd  out  1  ROM read enable; the ROM returns sti_di on the following negedge.
- sti_addr  out  10  ROM word address; word w holds row w>>3, cols (w&7)*16 .. +15.
- sti_di  in  16  ROM data; bit 15 is the leftmost pixel.
- res_wr  out  1  RAM write enable; the RAM writes on posedge.
- res_addr  out  14  pixel address = row*128 + col.
- res_do  out  8  pixel value to write.
- obj_cnt  out  15  number of pixels written as OBJ_VAL (0..16384).
- row_first  out  7  lowest row containing an object pixel.
- row_last  out  7  highest row containing an object pixel.
- row_valid  out  1  1 iff obj_cnt != 0.

## Operation
- States:
  - IDLE: waits for start.
  - FETCH: sti_rd=1, sti_addr=0; sti_di is captured into a 16-bit shift register at the closing posedge.
  - WRITE: one pixel per cycle, MSB first; 14-bit pixel counter k.
  - DONE: a one-cycle transition that sets done and returns to IDLE.
- Write rules:
  - In WRITE, res_wr=1, res_addr=k and res_do = (bit && !border) ? OBJ_VAL : 0. Border masking applies only when BORDER_ZERO=1.
  - The shift register advances once per cycle.
- Prefetch:
  - In the WRITE cycle where k[3:0]=15 and k<16368, assert sti_rd=1 with sti_addr=(k>>4)+1.
  - The next word is loaded into the shift register at that cycle's posedge.
  - The result is a gapless pixel stream.
- Exits:
  - WRITE with k=16383 -> DONE.
  - Then IDLE with done=1.
- Statistics, updated in the same cycle as each object write:
  - obj_cnt increments by 1.
  - On the first object write after start, set row_first=row_last=k[13:7].
  - On later object writes, row_last=k[13:7]. Rows are monotonic, so no compare is needed.
- Accepted start clears obj_cnt, row_first, row_last, row_valid and done.
- start while busy=1 is ignored.
- start in the same cycle that done is high is accepted and restarts the load.
- sti_rd=0 and res_wr=0 in all states other than those listed above. sti_addr, res_addr and res_do hold their last values when idle.
- All outputs come from registers or decode only registered state. There is no combinational path from start or sti_di to any output.

## Timing
- Reset (async, reset=0) forces state=IDLE and drives every output to 0.
- Reset asserted mid-load aborts immediately. No further sti_rd or res_wr is issued. Partially written RAM contents are not restored.
- Cycle numbering: start is sampled high at posedge P0.
  - Cycle 1: FETCH.
  - Cycles 2..16385: WRITE of pixel k in cycle k+2.
  - busy=1 in cycles 1..16385.
  - done and busy=0 from cycle 16386.
  - Total latency is 16385 cycles from start to the last RAM write.
- ROM reads: sti_rd is issued exactly 1024 times per load, one per word, in ascending order. There are never two consecutive sti_rd cycles.
- RAM writes: exactly 16384 writes per load, at addresses 0..16383 in ascending order, each in a single cycle.
- obj_cnt, row_first and row_last are final when done rises.

## Test plan
- Reset check: hold reset=0 for 3 cycles with start=1 -> every output is 0, and no sti_rd or res_wr is issued.
- All-zero ROM: pulse start -> 16384 writes of 0, done rises exactly 16386 cycles after P0, obj_cnt=0, row_valid=0.
- BORDER_ZERO=0, word0=16'h8001, all other words 0 -> res[0]=1, res[15]=1, all other pixels 0, obj_cnt=2, row_first=row_last=0, row_valid=1.
- BORDER_ZERO=1, word8=16'h8000, word9=16'hFFFF, word1023=16'hFFFF -> res[128]=0 (border, col 0), res[144..159]=1, row 127 all 0, obj_cnt=16, row_first=row_last=1.
- BORDER_ZERO=1, all-ones ROM, plus an extra start pulse at cycle 100 -> the second start is ignored, obj_cnt=15876 (126*126), row_first=1, row_last=126, res[129]=1, res[0]=0.
- Reset=0 at cycle 500 of a load, released, then start again -> outputs are 0 during reset, and the second load completes with correct RAM contents and a fresh obj_cnt.
